// File: rtl/systola_pkg.sv
// Shared definitions for the systolic array input path: default widths and the
// reader sequencer state encoding.
package systola_pkg;

  localparam int SYS_WORD_LEN   = 32;
  localparam int SYS_ADDR_LEN   = 10;
  localparam int SYS_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with occupancy count; buffers SRAM read data in front of
// the valid/ready stream so backpressure never drops or repeats a word.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assert property (@(posedge clk) disable iff (!resetn) !(push && full && !pop));

endmodule

// File: rtl/mem_stream_reader.sv
// Read-side sequencer for the input word SRAM: fetches a contiguous block and
// streams it out over valid/ready with credit-based flow control.
module mem_stream_reader
  import systola_pkg::*;
#(
  parameter int WORD_LEN   = SYS_WORD_LEN,
  parameter int ADDR_LEN   = SYS_ADDR_LEN,
  parameter int FIFO_DEPTH = SYS_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] base_addr,
  input  logic [ADDR_LEN:0]   len,
  output logic                busy,
  output logic                done,
  output logic                CEN,
  output logic                WEN,
  output logic [ADDR_LEN-1:0] A,
  input  logic [WORD_LEN-1:0] Q,
  output logic [WORD_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t              state;
  state_t              state_next;
  logic [ADDR_LEN-1:0] rd_addr;
  logic [ADDR_LEN-1:0] a_hold;
  logic [ADDR_LEN:0]   reads_left;
  logic                rd_pending;
  logic [1:0]          in_flight;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W:0]      occupancy;
  logic                issue_ok;
  logic                issue;
  logic                drain_done;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [WORD_LEN-1:0] fifo_head;

  stream_fifo #(
    .WIDTH (WORD_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (rd_pending),
    .push_data (Q),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // SRAM has one cycle of latency, so at most one read is ever in flight.
  assign in_flight = {1'b0, rd_pending};

  // Reserve a FIFO slot for every read before issuing it; overflow is impossible.
  always_comb begin
    occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(in_flight);
    issue_ok  = (occupancy < (CNT_W + 1)'(FIFO_DEPTH)) && (reads_left != '0);
  end

  assign issue      = (state == ISSUE) && issue_ok;
  assign out_valid  = !fifo_empty;
  assign out_data   = out_valid ? fifo_head : '0;
  assign fifo_pop   = out_valid && out_ready;
  // Drain finishes as the last word leaves, so FINISH follows the final handshake.
  assign drain_done = (in_flight == 2'd0) &&
                      ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = (len == '0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        if (issue && (reads_left == (ADDR_LEN + 1)'(1))) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_next = FINISH;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    CEN  = 1'b1;
    A    = a_hold;
    case (state)
      ISSUE: begin
        busy = 1'b1;
        if (issue_ok) begin
          CEN = 1'b0;
          A   = rd_addr;
        end
      end
      DRAIN:   busy = 1'b1;
      FINISH:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign WEN = 1'b1;

  // Transfer parameters are only captured from IDLE; later starts cannot disturb them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_addr    <= '0;
      reads_left <= '0;
      rd_pending <= 1'b0;
      a_hold     <= '0;
    end else begin
      rd_pending <= issue;
      a_hold     <= A;
      if ((state == IDLE) && start) begin
        rd_addr    <= base_addr;
        reads_left <= len;
      end else if (issue) begin
        rd_addr    <= rd_addr + ADDR_LEN'(1);
        reads_left <= reads_left - (ADDR_LEN + 1)'(1);
      end
    end
  end

  assert property (@(posedge clk) disable iff (!resetn)
                   occupancy <= (CNT_W + 1)'(FIFO_DEPTH));
  assert property (@(posedge clk) disable iff (!resetn) !(done && busy));

endmodule
